// File: rtl/allophone_sequencer.sv
// allophone_sequencer: host-side front end for the Speech256 core.
// Buffers host allophone codes in a small FIFO and hands them to the core
// one per ldq load request, with a watchdog on the ldq acknowledge.
// Optional build macro: ALLO_SEQ_AUTOPAUSE_EN (auto-insert PAUSE_CODE at phrase end).
module allophone_sequencer #(
  parameter int         DEPTH       = 16,
  parameter int         ADDR_W      = 4,
  parameter int         ACK_TIMEOUT = 1023,
  parameter logic [5:0] PAUSE_CODE  = 6'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        host_data,
  input  logic              host_wr,
  input  logic              flush,
  input  logic              clr_err,
  output logic              host_full,
  output logic [ADDR_W:0]   host_level,
  input  logic              ldq,
  output logic [5:0]        data_out,
  output logic              data_stb,
  output logic              busy,
  output logic              err_ovf,
  output logic              err_tmo
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_LDQ, ST_STROBE, ST_WAIT_DROP} state_t;

  logic [5:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   level_reg, level_next;
  logic              full_reg;
  state_t            state_reg;
  logic [15:0]       tmo_cnt_reg;
  logic [5:0]        data_out_reg;
  logic              data_stb_reg, err_ovf_reg, err_tmo_reg;

  logic fifo_empty, push_ok, ovf_ev, pop_head, tmo_ev, issue;
  logic pause_owed, pause_issue;

  assign fifo_empty = (level_reg == '0);
  // A write while full is dropped even if a pop happens in the same cycle.
  assign push_ok    = host_wr & ~flush & ~full_reg;
  assign ovf_ev     = host_wr & ~flush & full_reg;
  assign pop_head   = ~flush & ldq & ~fifo_empty &
                      ((state_reg == ST_IDLE) | (state_reg == ST_WAIT_LDQ));
  assign tmo_ev     = ~flush & ldq & (state_reg == ST_WAIT_DROP) & (tmo_cnt_reg == 16'd1);
  assign level_next = level_reg + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_head);

`ifdef ALLO_SEQ_AUTOPAUSE_EN
  // Set when the most recently issued code was the pause (or nothing is owed).
  logic last_pause_reg;
  assign pause_owed  = ~last_pause_reg;
  // Queued host codes take priority, which is how a late write cancels the pause.
  assign pause_issue = ~flush & ldq & fifo_empty & pause_owed &
                       ((state_reg == ST_IDLE) | (state_reg == ST_WAIT_LDQ));

  // Track whether a phrase-end pause is still owed to the core.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      last_pause_reg <= 1'b1;
    end else if (pop_head) begin
      last_pause_reg <= (mem[rd_ptr_reg] == PAUSE_CODE);
    end else if (pause_issue) begin
      last_pause_reg <= 1'b1;
    end
  end
`else
  assign pause_owed  = 1'b0;
  assign pause_issue = 1'b0;
`endif

  assign issue = pop_head | pause_issue;

  // FIFO storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= host_data;
    end
  end

  // FIFO pointers, handshake FSM, timeout counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      state_reg    <= ST_IDLE;
      tmo_cnt_reg  <= '0;
      data_out_reg <= '0;
      data_stb_reg <= 1'b0;
      err_ovf_reg  <= 1'b0;
      err_tmo_reg  <= 1'b0;
    end else begin
      data_stb_reg <= 1'b0;
      // A coincident error event beats clr_err.
      err_ovf_reg  <= ovf_ev | (err_ovf_reg & ~clr_err);
      err_tmo_reg  <= tmo_ev | (err_tmo_reg & ~clr_err);
      if (flush) begin
        // An already issued strobe is not recalled; only queued codes are lost.
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
        full_reg   <= 1'b0;
        state_reg  <= ST_IDLE;
      end else begin
        level_reg <= level_next;
        full_reg  <= (level_next == (ADDR_W+1)'(DEPTH));
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
        if (pop_head) begin
          rd_ptr_reg   <= rd_ptr_reg + ADDR_W'(1);
          data_out_reg <= mem[rd_ptr_reg];
        end else if (pause_issue) begin
          data_out_reg <= PAUSE_CODE;
        end
        case (state_reg)
          ST_IDLE: begin
            if (issue) begin
              data_stb_reg <= 1'b1;
              state_reg    <= ST_STROBE;
            end else if (~fifo_empty | pause_owed) begin
              state_reg <= ST_WAIT_LDQ;
            end
          end
          ST_WAIT_LDQ: begin
            if (issue) begin
              data_stb_reg <= 1'b1;
              state_reg    <= ST_STROBE;
            end else if (fifo_empty & ~pause_owed) begin
              state_reg <= ST_IDLE;
            end
          end
          ST_STROBE: begin
            tmo_cnt_reg <= 16'(ACK_TIMEOUT);
            state_reg   <= ST_WAIT_DROP;
          end
          ST_WAIT_DROP: begin
            // Either the core acknowledged or the watchdog gave up; the code is consumed.
            if (~ldq || (tmo_cnt_reg == 16'd1)) begin
              state_reg <= ST_IDLE;
            end else begin
              tmo_cnt_reg <= tmo_cnt_reg - 16'd1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign host_full  = full_reg;
  assign host_level = level_reg;
  assign data_out   = data_out_reg;
  assign data_stb   = data_stb_reg;
  assign err_ovf    = err_ovf_reg;
  assign err_tmo    = err_tmo_reg;
  assign busy       = ~fifo_empty | (state_reg != ST_IDLE) | pause_owed;

endmodule

// File: doc/allophone_sequencer.md
Name: allophone_sequencer

Overview:
Host-side front end for the Speech256 core. It buffers allophone codes written by a host (CPU, UART or ROM player) in a small FIFO. It then drives the core's ldq / data_in / data_stb load handshake, issuing exactly one code per load request. A timeout guards against the ldq handshake stalling, and overflow/timeout errors are reported as sticky status flags.

Parameters:
DEPTH, 16, FIFO depth in allophones; power of two, minimum 2.
ADDR_W, 4, log2(DEPTH).
ACK_TIMEOUT, 1023, cycles to wait for ldq to fall after a strobe; range 1..65535.
PAUSE_CODE, 6'h00, allophone auto-inserted at phrase end (used only with the optional feature).

Ports:
clk  in  1  Speech256 global clock.
rst  in  1  Reset, synchronous, active-high.
host_data  in  6  Allophone code from the host.
host_wr  in  1  Write strobe; host_data is pushed when host_wr=1 and the FIFO is not full.
flush  in  1  Discards the FIFO contents and aborts any pending issue.
clr_err  in  1  Clears the sticky error flags.
host_full  out  1  FIFO full.
host_level  out  ADDR_W+1  Current FIFO occupancy, 0..DEPTH.
ldq  in  1  Load request from the Speech256 controller.
data_out  out  6  Allophone code to the Speech256 data_in input.
data_stb  out  1  One-cycle load strobe to the Speech256 data_stb input.
busy  out  1  High when the FIFO is non-empty or the FSM is not in IDLE.
err_ovf  out  1  Sticky flag: a write was attempted while the FIFO was full.
err_tmo  out  1  Sticky flag: ldq did not fall within ACK_TIMEOUT cycles of a strobe.

Behaviour:
- Reset (rst=1 on a clk edge) sets all outputs to 0, except host_full=0 and host_level=0 as well. FIFO pointers go to 0 and the FSM goes to IDLE. The FIFO RAM contents are not reset.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - A simultaneous push and pop when the FIFO is full or empty is legal. When the FIFO is empty, only the push takes effect (no bypass). When the FIFO is full, the push is dropped and err_ovf is set, even though a pop occurs in the same cycle.
  - host_level and host_full are registered and update on the edge after the push or pop.
- FSM states:
  - IDLE: if the FIFO is non-empty and ldq=1, pop the head, register it onto data_out, assert data_stb for the next cycle, and go to STROBE. If the FIFO is non-empty and ldq=0, go to WAIT_LDQ.
  - WAIT_LDQ: stay while ldq=0. When ldq=1, pop, strobe, and go to STROBE.
  - STROBE: data_stb=1 for exactly one cycle. Load the timeout counter with ACK_TIMEOUT. Go to WAIT_DROP.
  - WAIT_DROP: the counter decrements each cycle. When ldq=0 is seen, go to IDLE. If the counter reaches 0 while ldq is still 1, set err_tmo and go to IDLE; the code counts as consumed.
- Latency: when ldq=1 and the FIFO is non-empty in IDLE, data_stb is high 1 cycle after that edge. data_out is valid in the same cycle as data_stb and holds its value until the next strobe.
- A new strobe is never issued until ldq has been seen low, or the timeout has fired. This prevents a double load while the core is still deasserting ldq.
- flush: on the next edge the FIFO is emptied and the FSM goes to IDLE. If a strobe has already been issued (STROBE or WAIT_DROP), that code is not recalled. A host_wr in the same cycle as flush is ignored. flush does not clear the error flags.
- clr_err clears both error flags on the next edge. If clr_err coincides with a new error event, the error wins (the flag stays set).
- rst mid-transfer: returns to IDLE immediately; data_stb is 0 on the following cycle.

Optional Feature:
Macro ALLO_SEQ_AUTOPAUSE_EN.
- Defined: when the FSM returns to IDLE with the FIFO empty, and the last issued code was not PAUSE_CODE, the block issues PAUSE_CODE through the normal handshake (WAIT_LDQ/STROBE/WAIT_DROP), exactly once per phrase. This silences the core at phrase end. busy stays high until that pause has been issued. A host write that arrives before the pause is issued cancels the pause.
- Undefined: no codes are inserted; behaviour is exactly as described above.

Test Plan:
1. After reset: push 6'h1B, 6'h07, 6'h2A with ldq held at 1. The model drops ldq 2 cycles after each strobe and raises it again 20 cycles later. Required: three strobes with data_out = 1B, 07, 2A in that order, each data_stb exactly 1 cycle wide, and host_level going 3 → 0.
2. Hold ldq=0 and push 17 codes with DEPTH=16. Required: host_full=1 after the 16th push, err_ovf=1 after the 17th push, host_level=16, no strobe issued. Then pulse clr_err: err_ovf=0.
3. Keep ldq stuck at 1 after a strobe, with ACK_TIMEOUT=8. Required: err_tmo rises 9 cycles after the strobe, and the next queued code is strobed once the FSM has passed through IDLE.
4. Queue 5 codes, then assert flush in the same cycle as host_wr of 6'h3F. Required: host_level=0 the next cycle, 6'h3F is absent, and no further strobes occur.
5. Simultaneous push and pop at level 1 while ldq=1. Required: level stays at 1, and codes come out in order.
6. With ALLO_SEQ_AUTOPAUSE_EN defined: push 6'h21 only. Required: strobes for 21 and then 00. busy falls after the second handshake completes.
